// File: rtl/memport_pkg.sv
// Shared types for the memport dual-bank byte memory port.
// MEMPORT_WRAPERR_EN (optional) turns a word access at 0xFFFF into an error response.
package memport_pkg;

  localparam int BANK_ROW_BITS = 15;
  localparam int ADDR_BITS     = 16;
  localparam int DATA_BITS     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Which bank(s) an access touches and in which byte order.
  typedef enum logic [1:0] {
    LANE_BYTE_EVEN = 2'd0,
    LANE_BYTE_ODD  = 2'd1,
    LANE_WORD_EVEN = 2'd2,
    LANE_WORD_ODD  = 2'd3
  } lane_sel_e;

  typedef logic [BANK_ROW_BITS-1:0] row_t;

  function automatic lane_sel_e lane_of(input logic word, input logic a0);
    lane_sel_e lane;
    case ({word, a0})
      2'b00:   lane = LANE_BYTE_EVEN;
      2'b01:   lane = LANE_BYTE_ODD;
      2'b10:   lane = LANE_WORD_EVEN;
      default: lane = LANE_WORD_ODD;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/memport_steer.sv
// Combinational byte-lane steering between a 16-bit big-endian request and the
// even/odd byte banks, for both the write path and the read-return path.
module memport_steer
  import memport_pkg::*;
(
  input  lane_sel_e   wr_lane,
  input  row_t        row,
  input  logic [15:0] wdata,
  output row_t        row_even,
  output row_t        row_odd,
  output logic [7:0]  data_even,
  output logic [7:0]  data_odd,
  output logic        touch_even,
  output logic        touch_odd,
  input  lane_sel_e   rd_lane,
  input  logic [7:0]  rd_even,
  input  logic [7:0]  rd_odd,
  output logic [15:0] rd_word
);

  always_comb begin
    row_even   = '0;
    row_odd    = '0;
    data_even  = '0;
    data_odd   = '0;
    touch_even = 1'b0;
    touch_odd  = 1'b0;
    case (wr_lane)
      LANE_BYTE_EVEN: begin
        touch_even = 1'b1;
        row_even   = row;
        data_even  = wdata[7:0];
      end
      LANE_BYTE_ODD: begin
        touch_odd = 1'b1;
        row_odd   = row;
        data_odd  = wdata[7:0];
      end
      LANE_WORD_EVEN: begin
        touch_even = 1'b1;
        touch_odd  = 1'b1;
        row_even   = row;
        row_odd    = row;
        data_even  = wdata[15:8];
        data_odd   = wdata[7:0];
      end
      default: begin
        // Odd word: low byte lives in the next even row, wrapping at 15 bits.
        touch_even = 1'b1;
        touch_odd  = 1'b1;
        row_odd    = row;
        row_even   = row + 1'b1;
        data_odd   = wdata[15:8];
        data_even  = wdata[7:0];
      end
    endcase
  end

  always_comb begin
    rd_word = '0;
    case (rd_lane)
      LANE_BYTE_EVEN: rd_word = {8'h00, rd_even};
      LANE_BYTE_ODD:  rd_word = {8'h00, rd_odd};
      LANE_WORD_EVEN: rd_word = {rd_even, rd_odd};
      default:        rd_word = {rd_odd, rd_even};
    endcase
  end

endmodule

// File: rtl/memport.sv
// 16-bit request/response port onto two byte-wide banks with one-cycle read latency.
// MEMPORT_WRAPERR_EN adds resp_err and rejects word accesses at 0xFFFF.
module memport
  import memport_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
`ifdef MEMPORT_WRAPERR_EN
  output logic        resp_err,
`endif
  output logic [14:0] dread_addr_even,
  output logic [14:0] dread_addr_odd,
  input  logic [7:0]  dread_data_even,
  input  logic [7:0]  dread_data_odd,
  output logic [14:0] dwrite_addr_even,
  output logic [14:0] dwrite_addr_odd,
  output logic [7:0]  dwrite_data_even,
  output logic [7:0]  dwrite_data_odd,
  output logic        dwrite_en_even,
  output logic        dwrite_en_odd
);

  // Handshake: a request transfers on req_valid && req_ready at a rising edge,
  // a response on resp_valid && resp_ready; response fields are frozen while
  // resp_valid && !resp_ready.

  state_e      state_q, state_d;
  lane_sel_e   lane_q, lane_d;
  logic        write_q, write_d;
  logic [15:0] hold_q, hold_d;

  logic        accept;
  logic        issue;
  logic        wrap_err;
  lane_sel_e   req_lane;
  row_t        row_even, row_odd;
  logic [7:0]  data_even, data_odd;
  logic        touch_even, touch_odd;
  logic [15:0] steer_rdata;
  logic [15:0] resp_data;

`ifdef MEMPORT_WRAPERR_EN
  logic err_q, err_d;
  logic hold_err_q, hold_err_d;
  assign wrap_err = req_word && (req_addr == 16'hFFFF);
`else
  assign wrap_err = 1'b0;
`endif

  assign accept   = req_valid && req_ready;
  assign issue    = accept && !wrap_err;
  assign req_lane = lane_of(req_word, req_addr[0]);

  memport_steer u_steer (
    .wr_lane    (req_lane),
    .row        (req_addr[15:1]),
    .wdata      (req_wdata),
    .row_even   (row_even),
    .row_odd    (row_odd),
    .data_even  (data_even),
    .data_odd   (data_odd),
    .touch_even (touch_even),
    .touch_odd  (touch_odd),
    .rd_lane    (lane_q),
    .rd_even    (dread_data_even),
    .rd_odd     (dread_data_odd),
    .rd_word    (steer_rdata)
  );

  always_comb begin
    dwrite_en_even   = 1'b0;
    dwrite_en_odd    = 1'b0;
    dwrite_addr_even = '0;
    dwrite_addr_odd  = '0;
    dwrite_data_even = '0;
    dwrite_data_odd  = '0;
    dread_addr_even  = '0;
    dread_addr_odd   = '0;
    if (issue && req_write) begin
      dwrite_en_even   = touch_even;
      dwrite_en_odd    = touch_odd;
      dwrite_addr_even = touch_even ? row_even : '0;
      dwrite_addr_odd  = touch_odd ? row_odd : '0;
      dwrite_data_even = touch_even ? data_even : '0;
      dwrite_data_odd  = touch_odd ? data_odd : '0;
    end
    if (issue && !req_write) begin
      dread_addr_even = touch_even ? row_even : '0;
      dread_addr_odd  = touch_odd ? row_odd : '0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lane_q  <= LANE_BYTE_EVEN;
      write_q <= 1'b0;
      hold_q  <= '0;
`ifdef MEMPORT_WRAPERR_EN
      err_q      <= 1'b0;
      hold_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      write_q <= write_d;
      hold_q  <= hold_d;
`ifdef MEMPORT_WRAPERR_EN
      err_q      <= err_d;
      hold_err_q <= hold_err_d;
`endif
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RESP;
      ST_RESP: begin
        if (!resp_ready)  state_d = ST_HOLD;
        else if (!accept) state_d = ST_IDLE;
      end
      ST_HOLD: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-request context captured on accept; the hold register snapshots a stalled response.
  always_comb begin
    lane_d  = accept ? req_lane : lane_q;
    write_d = accept ? req_write : write_q;
`ifdef MEMPORT_WRAPERR_EN
    err_d      = accept ? wrap_err : err_q;
    resp_data  = (write_q || err_q) ? 16'h0000 : steer_rdata;
    hold_err_d = (state_q == ST_RESP && !resp_ready) ? err_q : hold_err_q;
`else
    resp_data  = write_q ? 16'h0000 : steer_rdata;
`endif
    hold_d = (state_q == ST_RESP && !resp_ready) ? resp_data : hold_q;
  end

  // FSM: outputs
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
`ifdef MEMPORT_WRAPERR_EN
    resp_err   = 1'b0;
`endif
    if (reset) begin
      case (state_q)
        ST_IDLE: req_ready = 1'b1;
        ST_RESP: begin
          req_ready  = resp_ready;
          resp_valid = 1'b1;
          resp_rdata = resp_data;
`ifdef MEMPORT_WRAPERR_EN
          resp_err   = err_q;
`endif
        end
        ST_HOLD: begin
          resp_valid = 1'b1;
          resp_rdata = hold_q;
`ifdef MEMPORT_WRAPERR_EN
          resp_err   = hold_err_q;
`endif
        end
        default: req_ready = 1'b0;
      endcase
    end
  end

endmodule
